// File: rtl/instr_stream_loader.sv
// instr_stream_loader: receives the byte-serial instruction download stream,
// packs bytes little-endian into 32-bit words and writes them sequentially
// into instruction memory. Reaching the end marker raises a level "done"
// that releases the core to fetch from address 0.
module instr_stream_loader #(
  parameter int          MAX_WORDS  = 64,
  parameter int          ADDR_W     = 6,
  parameter logic [7:0]  START_BYTE = 8'hFE,
  parameter logic [7:0]  END_BYTE   = 8'hFF
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [7:0]        instr_i,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              loading,
  output logic              done,
  output logic              overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // word_count value just before the final word that fills memory is written
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(MAX_WORDS - 1);

  logic [1:0]        state;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] ptr;
  logic [23:0]       shift_buf;

  // Status levels decode straight from the state register
  assign loading = (state == S_LOAD) || (state == S_FULL);
  assign done    = (state == S_DONE);

  // Stream parser: marker detection, byte packing and memory write generation
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state      <= S_IDLE;
      byte_idx   <= 2'd0;
      ptr        <= '0;
      shift_buf  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_i == START_BYTE) begin
            state      <= S_LOAD;
            byte_idx   <= 2'd0;
            ptr        <= '0;
            word_count <= '0;
          end
        end
        S_LOAD: begin
          if (byte_idx == 2'd0 && instr_i == END_BYTE) begin
            state <= S_DONE;
          end else if (byte_idx == 2'd0 && instr_i == START_BYTE) begin
            ptr        <= '0;
            word_count <= '0;
          end else begin
            case (byte_idx)
              2'd0: shift_buf[7:0]   <= instr_i;
              2'd1: shift_buf[15:8]  <= instr_i;
              2'd2: shift_buf[23:16] <= instr_i;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= ptr;
                imem_wdata <= {instr_i, shift_buf};
                word_count <= word_count + 1'b1;
                if (word_count == LAST_COUNT) begin
                  state <= S_FULL;
                end else begin
                  ptr <= ptr + 1'b1;
                end
              end
            endcase
            byte_idx <= byte_idx + 1'b1;
          end
        end
        S_FULL: begin
          state    <= S_DONE;
          overflow <= (instr_i != END_BYTE);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_loader.sv
// tb_instr_stream_loader: scoreboard bench for instr_stream_loader. Expected
// memory writes are queued as stimulus is driven and popped by a monitor
// whenever the design raises imem_we.
module tb_instr_stream_loader;

  logic        clk_i;
  logic        reset;
  logic [7:0]  instr_i;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  word_count;
  logic        loading;
  logic        done;
  logic        overflow;

  int total;
  int bad;
  int pulses;
  logic [37:0] exp_q[$];

  instr_stream_loader dut (
    .clk_i      (clk_i),
    .reset      (reset),
    .instr_i    (instr_i),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_count (word_count),
    .loading    (loading),
    .done       (done),
    .overflow   (overflow)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk_i) begin
    if (imem_we === 1'b1) begin
      logic [37:0] e;
      pulses = pulses + 1;
      total  = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_write got addr=%0d data=%h want no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          bad = bad + 1;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   imem_addr, imem_wdata, e[37:32], e[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    instr_i = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_write(input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    instr_i = 8'h00;
    @(posedge clk_i);
    #1;
    reset = 1'b0;
    exp_q.delete();
    pulses = 0;
  endtask

  // Common end-of-stream checks
  task automatic check_end(input string name, input int exp_pulses, input logic [6:0] exp_wc,
                           input logic exp_done, input logic exp_ovf);
    total++;
    if (pulses !== exp_pulses) begin
      bad++; $display("FAIL %s_pulses got %0d want %0d", name, pulses, exp_pulses);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL %s_missing got %0d pending want 0", name, exp_q.size());
    end
    total++;
    if (word_count !== exp_wc) begin
      bad++; $display("FAIL %s_word_count got %0d want %0d", name, word_count, exp_wc);
    end
    total++;
    if (done !== exp_done) begin
      bad++; $display("FAIL %s_done got %b want %b", name, done, exp_done);
    end
    total++;
    if (overflow !== exp_ovf) begin
      bad++; $display("FAIL %s_overflow got %b want %b", name, overflow, exp_ovf);
    end
    total++;
    if (loading !== 1'b0) begin
      bad++; $display("FAIL %s_loading got %b want 0", name, loading);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    instr_i = 8'hFE;
    @(posedge clk_i);
    #1;
    total++;
    if ({imem_we, imem_addr, imem_wdata, word_count, loading, done, overflow} !== 49'd0) begin
      bad++;
      $display("FAIL reset_outputs got we=%b addr=%h data=%h wc=%h ld=%b dn=%b ov=%b want all 0",
               imem_we, imem_addr, imem_wdata, word_count, loading, done, overflow);
    end
    reset = 1'b0;
    exp_q.delete();
    pulses = 0;
  endtask

  task automatic test_single_word();
    logic [7:0] s[9] = '{8'h00, 8'h00, 8'h00, 8'hFE, 8'h13, 8'h05, 8'h10, 8'h00, 8'hFF};
    do_reset();
    push_write(6'd0, 32'h00100513);
    for (int i = 0; i < 8; i++) send_byte(s[i]);
    total++;
    if (loading !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL single_loading got ld=%b dn=%b want ld=1 dn=0", loading, done);
    end
    send_byte(s[8]);
    check_end("single", 1, 7'd1, 1'b1, 1'b0);
    total++;
    if (imem_wdata !== 32'h00100513 || imem_addr !== 6'd0) begin
      bad++; $display("FAIL single_hold got addr=%0d data=%h want addr=0 data=00100513", imem_addr, imem_wdata);
    end
  endtask

  task automatic test_after_done();
    logic [7:0] s[5] = '{8'hFE, 8'h13, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) send_byte(s[i]);
    send_byte(8'h00);
    check_end("after_done", 1, 7'd1, 1'b1, 1'b0);
  endtask

  task automatic test_ff_midword();
    logic [7:0] s[10] = '{8'hFE, 8'h93, 8'h80, 8'hF0, 8'hFF, 8'h13, 8'h00, 8'h00, 8'h00, 8'hFF};
    do_reset();
    push_write(6'd0, 32'hFFF08093);
    push_write(6'd1, 32'h00000013);
    for (int i = 0; i < 10; i++) send_byte(s[i]);
    check_end("midword", 2, 7'd2, 1'b1, 1'b0);
  endtask

  task automatic test_full(input logic [7:0] last, input logic exp_ovf);
    do_reset();
    send_byte(8'hFE);
    for (int k = 0; k < 64; k++) begin
      push_write(6'(k), 32'(k));
      send_byte(8'(k));
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
    end
    total++;
    if (loading !== 1'b1 || done !== 1'b0 || word_count !== 7'd64) begin
      bad++; $display("FAIL full_state got ld=%b dn=%b wc=%0d want ld=1 dn=0 wc=64", loading, done, word_count);
    end
    send_byte(last);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    check_end(exp_ovf ? "full_ovf" : "full_end", 64, 7'd64, 1'b1, exp_ovf);
  endtask

  task automatic test_mid_reset();
    logic [7:0] s[6] = '{8'hFE, 8'h13, 8'h05, 8'h10, 8'h00, 8'hFF};
    do_reset();
    send_byte(8'hFE);
    send_byte(8'h13);
    send_byte(8'h05);
    reset   = 1'b1;
    instr_i = 8'h10;
    @(posedge clk_i);
    #1;
    total++;
    if ({imem_we, imem_addr, imem_wdata, word_count, loading, done, overflow} !== 49'd0 || pulses !== 0) begin
      bad++;
      $display("FAIL midreset_outputs got we=%b wc=%0d ld=%b pulses=%0d want all 0",
               imem_we, word_count, loading, pulses);
    end
    reset = 1'b0;
    push_write(6'd0, 32'h00100513);
    for (int i = 0; i < 6; i++) send_byte(s[i]);
    check_end("midreset", 1, 7'd1, 1'b1, 1'b0);
  endtask

  task automatic test_restart();
    logic [7:0] s[13] = '{8'hFF, 8'h00, 8'hFE, 8'h13, 8'h00, 8'h00, 8'h00,
                          8'hFE, 8'hB3, 8'h00, 8'h00, 8'h00, 8'hFF};
    do_reset();
    push_write(6'd0, 32'h00000013);
    push_write(6'd0, 32'h000000B3);
    send_byte(s[0]);
    send_byte(s[1]);
    total++;
    if (loading !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL restart_idle got ld=%b dn=%b want 0 0", loading, done);
    end
    for (int i = 2; i < 13; i++) send_byte(s[i]);
    check_end("restart", 2, 7'd1, 1'b1, 1'b0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    pulses  = 0;
    reset   = 1'b1;
    instr_i = 8'h00;
    test_reset();
    test_single_word();
    test_after_done();
    test_ff_midword();
    test_full(8'hFF, 1'b0);
    test_full(8'h13, 1'b1);
    test_mid_reset();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
